mlsu_meta_sequencer: RTL and testbench
======================================

Name: mlsu_meta_sequencer

Overview:
- Converts one matrix load/store request into a stream of per-transaction meta beats for the MLSU transaction control unit.
- A request covers a base address, a row stride and a row count; each row (segment) is split at 4 KiB page boundaries, and one meta beat is emitted per page-bounded transaction.
- Sits between the MLSU request decoder and the transaction control unit's meta_valid/meta_ready interface.
- All addresses and lengths are in nibbles.

Parameters:
- AddrWidth, 64 (riva_pkg::ELEN): nibble-address width.
- SegNumWidth, 16: width of the segment (row) count.
- SegLenWidth, 20: width of nibbles per segment.
- StrideWidth, 32: width of the unsigned row stride in nibbles.
- mlsu_req_t, logic: request type with fields reqId, isLoad, baseAddr, stride, segNum, segNibbles.
- meta_glb_t, logic: meta type with fields reqId, isLoad, rmnSeg.
- meta_seglv_t, logic: meta type with fields segBaseAddr, txnCnt, txnNum, ltN.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with valid.
- req_i  in  mlsu_req_t  request payload.
- meta_valid_o  out  1  meta beat valid.
- meta_ready_i  in  1  downstream ready.
- meta_glb_o  out  meta_glb_t  request-level meta.
- meta_seglv_o  out  meta_seglv_t  segment/transaction-level meta.
- busy_o  out  1  a request is in progress.
- done_o  out  1  one-cycle pulse when the request has fully issued.

Behaviour:
- Reset (async, active-low): state IDLE; all counters zero; meta_valid_o=0, meta_glb_o='0, meta_seglv_o='0, busy_o=0, done_o=0. req_ready_o follows state, so it is 1 after reset.
- A reset mid-operation discards the request and emits no further beats.
- FSM has three states: IDLE, CALC, EMIT.
- IDLE:
  - req_ready_o=1.
  - On handshake, latch the request, set segIdx=0, curBase=baseAddr.
  - If segNum==0 or segNibbles==0: stay in IDLE, pulse done_o next cycle, emit no meta.
  - Otherwise go to CALC.
- CALC (one cycle, registered):
  - pageOff = curBase[12:0].
  - endOff = pageOff + segNibbles - 1.
  - txnNum = endOff >> 13.
  - ltN = endOff[12:0] + 1, 14 bits, range 1..8192.
  - rmnSeg = segNum - 1 - segIdx.
  - txnCnt=0. Go to EMIT.
- EMIT:
  - meta_valid_o=1; fields driven from registers.
  - segBaseAddr is curBase for every beat of the segment.
  - txnCnt counts 0..txnNum.
  - The payload is held stable while valid && !ready; valid never drops without a handshake.
  - On handshake with txnCnt<txnNum: txnCnt+1.
  - On handshake with txnCnt==txnNum and rmnSeg!=0: curBase += stride (modulo 2^AddrWidth), segIdx+1, go to CALC.
  - On handshake with txnCnt==txnNum and rmnSeg==0: go to IDLE and assert done_o in the same cycle as that handshake.
- busy_o=1 in CALC and EMIT.
- Throughput: 1 beat/cycle within a segment; 1 bubble cycle per segment, caused by CALC.
- req_ready_o=0 outside IDLE. The next request is accepted one cycle after done_o at the earliest.
- Width rules:
  - endOff is computed at SegLenWidth+1 bits so it cannot overflow.
  - txnNum is SegLenWidth-12 bits wide.
  - The segBaseAddr add wraps silently.
  - pageOff+segNibbles crossing exactly to 8192 gives txnNum=0, ltN=8192.
- Assertions:
  - meta payload stable under backpressure.
  - ltN in 1..8192.
  - txnCnt<=txnNum.
  - req_valid_i with req_ready_o=0 must hold req_i stable (upstream contract, checked).

Decomposition:
- mlsu_pkg holds: PageNibbles=8192, PageOffBits=13, mlsu_req_t, meta_glb_t, meta_seglv_t, and the FSM state enum.
- The CALC arithmetic is isolated in mlsu_seg_splitter: a combinational calculator with inputs base and segNibbles, outputs txnNum and ltN. It is reusable by the store-data alignment logic.
- All other logic stays in this module.

Test Plan:
- Single aligned row: base=0x0, segNum=1, segNibbles=256 -> 1 beat: txnCnt=0, txnNum=0, ltN=256, rmnSeg=0; done_o in the same cycle as the handshake.
- Page crossing: base=0x1F00, segNibbles=512, segNum=1 -> 2 beats: txnNum=1 on both, ltN=256, segBaseAddr=0x1F00 on both; txnCnt=0 then 1.
- Strided 3 rows: base=0x100, stride=0x2000, segNibbles=64 -> 3 beats, segBaseAddr 0x100/0x2100/0x4100, rmnSeg 2/1/0. Exactly one idle bubble between beats with meta_ready_i held at 1.
- Backpressure: meta_ready_i low for 5 cycles mid-request -> meta_valid_o stays 1 and the payload is unchanged; beat count and order are identical to the no-stall run.
- Zero-length: segNibbles=0, segNum=4 -> no meta_valid_o; done_o pulses 1 cycle after accept; req_ready_o returns to 1.
- Reset mid-EMIT: assert rst_ni=0 during a beat of a 3-row request -> meta_valid_o=0 and busy_o=0 immediately; after release, a new request issues correctly from segIdx 0.

Source files
------------

// File: rtl/mlsu_pkg.sv
// Shared widths, request/meta payload types and FSM states for the MLSU meta sequencer.
package mlsu_pkg;

  localparam int unsigned AddrWidth   = 64;
  localparam int unsigned SegNumWidth = 16;
  localparam int unsigned SegLenWidth = 20;
  localparam int unsigned StrideWidth = 32;
  localparam int unsigned ReqIdWidth  = 4;

  localparam int unsigned PageNibbles = 8192;
  localparam int unsigned PageOffBits = 13;
  // endOff is SegLenWidth+1 bits, so the page index above the offset is SegLenWidth-12 bits.
  localparam int unsigned TxnWidth    = SegLenWidth - (PageOffBits - 1);
  localparam int unsigned LtnWidth    = PageOffBits + 1;

  typedef struct packed {
    logic [ReqIdWidth-1:0]  reqId;
    logic                   isLoad;
    logic [AddrWidth-1:0]   baseAddr;
    logic [StrideWidth-1:0] stride;
    logic [SegNumWidth-1:0] segNum;
    logic [SegLenWidth-1:0] segNibbles;
  } mlsu_req_t;

  typedef struct packed {
    logic [ReqIdWidth-1:0]  reqId;
    logic                   isLoad;
    logic [SegNumWidth-1:0] rmnSeg;
  } meta_glb_t;

  typedef struct packed {
    logic [AddrWidth-1:0] segBaseAddr;
    logic [TxnWidth-1:0]  txnCnt;
    logic [TxnWidth-1:0]  txnNum;
    logic [LtnWidth-1:0]  ltN;
  } meta_seglv_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_EMIT
  } mlsu_state_e;

endpackage

// File: rtl/mlsu_seg_splitter.sv
// Combinational page splitter: transaction count and last-transaction length for one
// segment starting at base_i and spanning seg_nibbles_i nibbles (seg_nibbles_i >= 1).
module mlsu_seg_splitter
  import mlsu_pkg::*;
(
  input  logic [AddrWidth-1:0]   base_i,
  input  logic [SegLenWidth-1:0] seg_nibbles_i,
  output logic [TxnWidth-1:0]    txn_num_o,
  output logic [LtnWidth-1:0]    ltn_o
);

  localparam int unsigned EndW = SegLenWidth + 1;

  logic [EndW-1:0] end_off;
  logic            unused_base_hi;

  // Offset of the last nibble relative to the start of the first page.
  assign end_off   = EndW'(base_i[PageOffBits-1:0]) + EndW'(seg_nibbles_i) - EndW'(1);
  assign txn_num_o = end_off[EndW-1:PageOffBits];
  assign ltn_o     = LtnWidth'(end_off[PageOffBits-1:0]) + LtnWidth'(1);

  assign unused_base_hi = ^base_i[AddrWidth-1:PageOffBits];

endmodule

// File: rtl/mlsu_meta_sequencer.sv
// Turns one matrix load/store request into a stream of page-bounded meta beats,
// one segment (row) at a time, with a one-cycle CALC bubble between segments.
//
// Handshakes: both req and meta use valid/ready; a transfer happens on the rising
// clock edge where valid and ready are both high. Once meta_valid_o rises its payload
// holds until that transfer; upstream must hold req_i while req_valid_i waits on ready.
module mlsu_meta_sequencer
  import mlsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  mlsu_req_t   req_i,
  output logic        meta_valid_o,
  input  logic        meta_ready_i,
  output meta_glb_t   meta_glb_o,
  output meta_seglv_t meta_seglv_o,
  output logic        busy_o,
  output logic        done_o
);

  mlsu_state_e            state_q, state_d;
  mlsu_req_t              req_q, req_d;
  logic [SegNumWidth-1:0] seg_idx_q, seg_idx_d;
  logic [AddrWidth-1:0]   cur_base_q, cur_base_d;
  logic [TxnWidth-1:0]    txn_cnt_q, txn_cnt_d;
  logic [TxnWidth-1:0]    txn_num_q, txn_num_d;
  logic [LtnWidth-1:0]    ltn_q, ltn_d;
  logic [SegNumWidth-1:0] rmn_seg_q, rmn_seg_d;
  logic                   done_q, done_d;

  logic [TxnWidth-1:0] split_txn_num;
  logic [LtnWidth-1:0] split_ltn;
  logic                req_hs;
  logic                meta_hs;
  logic                last_txn;
  logic                last_seg;

  mlsu_seg_splitter u_splitter (
    .base_i        (cur_base_q),
    .seg_nibbles_i (req_q.segNibbles),
    .txn_num_o     (split_txn_num),
    .ltn_o         (split_ltn)
  );

  // done_q blocks acceptance for the cycle of a zero-length done pulse.
  assign req_ready_o  = (state_q == ST_IDLE) && !done_q;
  assign meta_valid_o = (state_q == ST_EMIT);
  assign busy_o       = (state_q != ST_IDLE);
  assign req_hs       = req_valid_i && req_ready_o;
  assign meta_hs      = meta_valid_o && meta_ready_i;
  assign last_txn     = (txn_cnt_q == txn_num_q);
  assign last_seg     = (rmn_seg_q == '0);
  assign done_o       = done_q || (meta_hs && last_txn && last_seg);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    seg_idx_d  = seg_idx_q;
    cur_base_d = cur_base_q;
    txn_cnt_d  = txn_cnt_q;
    txn_num_d  = txn_num_q;
    ltn_d      = ltn_q;
    rmn_seg_d  = rmn_seg_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          req_d      = req_i;
          seg_idx_d  = '0;
          cur_base_d = req_i.baseAddr;
          if ((req_i.segNum == '0) || (req_i.segNibbles == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        txn_num_d = split_txn_num;
        ltn_d     = split_ltn;
        rmn_seg_d = req_q.segNum - SegNumWidth'(1) - seg_idx_q;
        txn_cnt_d = '0;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        if (meta_hs) begin
          if (!last_txn) begin
            txn_cnt_d = txn_cnt_q + TxnWidth'(1);
          end else if (!last_seg) begin
            cur_base_d = cur_base_q + {{(AddrWidth-StrideWidth){1'b0}}, req_q.stride};
            seg_idx_d  = seg_idx_q + SegNumWidth'(1);
            state_d    = ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    meta_glb_o   = '0;
    meta_seglv_o = '0;
    if (state_q == ST_EMIT) begin
      meta_glb_o.reqId         = req_q.reqId;
      meta_glb_o.isLoad        = req_q.isLoad;
      meta_glb_o.rmnSeg        = rmn_seg_q;
      meta_seglv_o.segBaseAddr = cur_base_q;
      meta_seglv_o.txnCnt      = txn_cnt_q;
      meta_seglv_o.txnNum      = txn_num_q;
      meta_seglv_o.ltN         = ltn_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      seg_idx_q  <= '0;
      cur_base_q <= '0;
      txn_cnt_q  <= '0;
      txn_num_q  <= '0;
      ltn_q      <= '0;
      rmn_seg_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      seg_idx_q  <= seg_idx_d;
      cur_base_q <= cur_base_d;
      txn_cnt_q  <= txn_cnt_d;
      txn_num_q  <= txn_num_d;
      ltn_q      <= ltn_d;
      rmn_seg_q  <= rmn_seg_d;
      done_q     <= done_d;
    end
  end

  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (meta_valid_o && !meta_ready_i) |=>
      (meta_valid_o && $stable(meta_glb_o) && $stable(meta_seglv_o)));

  a_ltn_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    meta_valid_o |-> ((ltn_q != '0) && (ltn_q <= LtnWidth'(PageNibbles))));

  a_txn_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_EMIT) |-> (txn_cnt_q <= txn_num_q));

  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && !req_ready_o) |=> $stable(req_i));

endmodule

// File: tb/tb_mlsu_meta_sequencer.sv
// Directed, table-driven bench for mlsu_meta_sequencer with hand-computed meta beats.
module tb_mlsu_meta_sequencer;
  import mlsu_pkg::*;

  typedef struct packed {
    meta_glb_t   glb;
    meta_seglv_t seg;
  } beat_t;

  localparam int BeatW = $bits(beat_t);

  typedef struct {
    mlsu_req_t req;
    int        first;
    int        nbeats;
    int        stall_at;
  } req_ent_t;

  typedef struct {
    beat_t beat;
    int    gap;
  } beat_ent_t;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  mlsu_req_t   req_i;
  logic        meta_valid_o;
  logic        meta_ready_i;
  meta_glb_t   meta_glb_o;
  meta_seglv_t meta_seglv_o;
  logic        busy_o;
  logic        done_o;

  req_ent_t         req_tab[$];
  beat_ent_t        beat_tab[$];
  logic [BeatW-1:0] exp_q[$];
  int               gap_q[$];
  int               n_checks;
  int               n_errors;

  mlsu_meta_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_i        (req_i),
    .meta_valid_o (meta_valid_o),
    .meta_ready_i (meta_ready_i),
    .meta_glb_o   (meta_glb_o),
    .meta_seglv_o (meta_seglv_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_req(input logic [ReqIdWidth-1:0] id, input logic ld,
                         input logic [AddrWidth-1:0] base, input logic [StrideWidth-1:0] stride,
                         input logic [SegNumWidth-1:0] seg_num, input logic [SegLenWidth-1:0] nib,
                         input int nbeats, input int stall_at);
    req_ent_t e;
    e.req.reqId      = id;
    e.req.isLoad     = ld;
    e.req.baseAddr   = base;
    e.req.stride     = stride;
    e.req.segNum     = seg_num;
    e.req.segNibbles = nib;
    e.first          = beat_tab.size();
    e.nbeats         = nbeats;
    e.stall_at       = stall_at;
    req_tab.push_back(e);
  endtask

  task automatic add_beat(input logic [ReqIdWidth-1:0] id, input logic ld,
                          input logic [SegNumWidth-1:0] rmn, input logic [AddrWidth-1:0] base,
                          input logic [TxnWidth-1:0] cnt, input logic [TxnWidth-1:0] num,
                          input logic [LtnWidth-1:0] ltn, input int gap);
    beat_ent_t b;
    b.beat.glb.reqId       = id;
    b.beat.glb.isLoad      = ld;
    b.beat.glb.rmnSeg      = rmn;
    b.beat.seg.segBaseAddr = base;
    b.beat.seg.txnCnt      = cnt;
    b.beat.seg.txnNum      = num;
    b.beat.seg.ltN         = ltn;
    b.gap                  = gap;
    beat_tab.push_back(b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input mlsu_req_t rq);
    bit ok;
    ok = 1'b0;
    @(negedge clk_i);
    req_i       = rq;
    req_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check("req_accept", 128'(ok), 128'(1));
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic run_req(input int r);
    req_ent_t e;
    int       beats;
    int       last_cyc;
    int       left;
    bit       stalled;
    bit       fin;
    e = req_tab[r];
    exp_q.delete();
    gap_q.delete();
    for (int i = 0; i < e.nbeats; i++) begin
      exp_q.push_back(beat_tab[e.first + i].beat);
      gap_q.push_back(beat_tab[e.first + i].gap);
    end
    meta_ready_i = 1'b1;
    send_req(e.req);
    beats    = 0;
    last_cyc = 0;
    left     = 0;
    stalled  = 1'b0;
    fin      = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clk_i);
      if (meta_valid_o) begin
        check("busy_in_emit", 128'(busy_o), 128'(1));
        if (exp_q.size() > 0) check("beat_payload", 128'({meta_glb_o, meta_seglv_o}), 128'(exp_q[0]));
        else                  check("extra_beat", 128'(1), 128'(0));
      end else begin
        check("done_without_beat", 128'(done_o), 128'(0));
      end
      if (!meta_ready_i) begin
        left--;
        if (left <= 0) meta_ready_i = 1'b1;
      end else if (meta_valid_o && e.stall_at == beats && !stalled) begin
        meta_ready_i = 1'b0;
        stalled      = 1'b1;
        left         = 5;
      end
      #1;
      if (meta_valid_o && meta_ready_i && exp_q.size() > 0) begin
        if (gap_q[0] > 0) check("beat_gap", 128'(cyc - last_cyc), 128'(gap_q[0]));
        check("done_on_handshake", 128'(done_o), 128'(exp_q.size() == 1));
        void'(exp_q.pop_front());
        void'(gap_q.pop_front());
        last_cyc = cyc;
        beats++;
        if (exp_q.size() == 0) fin = 1'b1;
      end
    end
    check("beat_count", 128'(beats), 128'(e.nbeats));
    @(negedge clk_i);
    check("post_ready", 128'(req_ready_o), 128'(1));
    check("post_busy", 128'(busy_o), 128'(0));
    check("post_valid", 128'(meta_valid_o), 128'(0));
    check("post_done", 128'(done_o), 128'(0));
  endtask

  task automatic run_zero(input mlsu_req_t rq);
    meta_ready_i = 1'b1;
    send_req(rq);
    @(negedge clk_i);
    check("zero_done_pulse", 128'(done_o), 128'(1));
    check("zero_ready_low", 128'(req_ready_o), 128'(0));
    check("zero_no_valid", 128'(meta_valid_o), 128'(0));
    check("zero_not_busy", 128'(busy_o), 128'(0));
    @(negedge clk_i);
    check("zero_done_clear", 128'(done_o), 128'(0));
    check("zero_ready_back", 128'(req_ready_o), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("zero_stays_quiet", 128'({meta_valid_o, busy_o, done_o}), 128'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mlsu_req_t rq;
    bit        seen;
    n_checks     = 0;
    n_errors     = 0;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_i        = '0;
    meta_ready_i = 1'b0;

    // id, ld, base, stride, segNum, nibbles, nbeats, stall_at
    add_req(4'd1, 1'b1, 64'h0, 32'h0, 16'd1, 20'd256, 1, -1);
    add_beat(4'd1, 1'b1, 16'd0, 64'h0, 8'd0, 8'd0, 14'd256, 0);
    add_req(4'd2, 1'b0, 64'h1F00, 32'h0, 16'd1, 20'd512, 2, -1);
    add_beat(4'd2, 1'b0, 16'd0, 64'h1F00, 8'd0, 8'd1, 14'd256, 0);
    add_beat(4'd2, 1'b0, 16'd0, 64'h1F00, 8'd1, 8'd1, 14'd256, 1);
    add_req(4'd3, 1'b1, 64'h100, 32'h2000, 16'd3, 20'd64, 3, -1);
    add_beat(4'd3, 1'b1, 16'd2, 64'h100, 8'd0, 8'd0, 14'd320, 0);
    add_beat(4'd3, 1'b1, 16'd1, 64'h2100, 8'd0, 8'd0, 14'd320, 2);
    add_beat(4'd3, 1'b1, 16'd0, 64'h4100, 8'd0, 8'd0, 14'd320, 2);
    add_req(4'd4, 1'b1, 64'h100, 32'h2000, 16'd3, 20'd64, 3, 1);
    add_beat(4'd4, 1'b1, 16'd2, 64'h100, 8'd0, 8'd0, 14'd320, -1);
    add_beat(4'd4, 1'b1, 16'd1, 64'h2100, 8'd0, 8'd0, 14'd320, -1);
    add_beat(4'd4, 1'b1, 16'd0, 64'h4100, 8'd0, 8'd0, 14'd320, -1);
    add_req(4'd5, 1'b0, 64'h1000, 32'h1000, 16'd2, 20'd4096, 2, -1);
    add_beat(4'd5, 1'b0, 16'd1, 64'h1000, 8'd0, 8'd0, 14'd8192, 0);
    add_beat(4'd5, 1'b0, 16'd0, 64'h2000, 8'd0, 8'd0, 14'd4096, 2);
    add_req(4'd6, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 32'h2000, 16'd2, 20'h1000, 2, -1);
    add_beat(4'd6, 1'b1, 16'd1, 64'hFFFF_FFFF_FFFF_F000, 8'd0, 8'd0, 14'd8192, 0);
    add_beat(4'd6, 1'b1, 16'd0, 64'h0000_0000_0000_1000, 8'd0, 8'd0, 14'd8192, 2);
    add_req(4'd7, 1'b0, 64'h0, 32'h0, 16'd1, 20'h4001, 3, -1);
    add_beat(4'd7, 1'b0, 16'd0, 64'h0, 8'd0, 8'd2, 14'd1, 0);
    add_beat(4'd7, 1'b0, 16'd0, 64'h0, 8'd1, 8'd2, 14'd1, 1);
    add_beat(4'd7, 1'b0, 16'd0, 64'h0, 8'd2, 8'd2, 14'd1, 1);

    // reset state
    repeat (2) @(negedge clk_i);
    check("rst_valid", 128'(meta_valid_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_ready", 128'(req_ready_o), 128'(1));
    check("rst_payload", 128'({meta_glb_o, meta_seglv_o}), 128'(0));
    rst_ni = 1'b1;

    for (int r = 0; r < req_tab.size(); r++) run_req(r);

    // zero-length requests: no beats, done one cycle after accept
    rq = '0;
    rq.reqId = 4'd9; rq.segNum = 16'd4; rq.segNibbles = 20'd0; rq.baseAddr = 64'h80;
    run_zero(rq);
    rq.reqId = 4'd10; rq.segNum = 16'd0; rq.segNibbles = 20'd100;
    run_zero(rq);

    // reset in the middle of a strided request
    meta_ready_i = 1'b1;
    rq = req_tab[2].req;
    rq.reqId = 4'd11;
    send_req(rq);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (meta_valid_o && meta_glb_o.rmnSeg == 16'd1) seen = 1'b1;
    end
    check("mid_beat_reached", 128'(seen), 128'(1));
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 128'(meta_valid_o), 128'(0));
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_ready", 128'(req_ready_o), 128'(1));
    check("midrst_payload", 128'({meta_glb_o, meta_seglv_o}), 128'(0));
    repeat (2) @(negedge clk_i);
    check("midrst_quiet", 128'({meta_valid_o, busy_o, done_o}), 128'(0));
    rst_ni = 1'b1;
    run_req(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
